// File: rtl/uart_program_loader.sv
// Boot loader: receives a length-prefixed program image over UART, writes it into BRAM,
// then hands the BRAM port to the core. Define LOADER_CHECKSUM_EN for a trailing XOR checksum byte.
module uart_program_loader #(
  parameter int CLK_PER_BIT = 868,
  parameter int ADDR_W      = 20
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              rxd,
  output logic              core_rstn,
  input  logic [31:0]       core_adr,
  input  logic [31:0]       core_writedata,
  input  logic              core_memwrite,
  output logic [31:0]       core_readdata,
  output logic [ADDR_W-1:0] addra,
  output logic              wea,
  output logic [31:0]       dina,
  input  logic [31:0]       douta,
  output logic              load_done,
  output logic              load_err
);

  // state     | meaning
  // RX_IDLE   | line idle, waiting for a low level
  // RX_START  | half-bit check that the start bit is real
  // RX_DATA   | sampling 8 data bits, LSB first
  // RX_STOP   | sampling the stop bit
  // LD_LEN    | collecting the 4-byte little-endian word count
  // LD_DATA   | collecting data words and writing them to BRAM
  // LD_CSUM   | waiting for the checksum byte (checksum build only)
  // LD_RUN    | core owns the BRAM port and runs
  // LD_HALT   | load aborted, core held in reset until rstn
  localparam logic [1:0] RX_IDLE  = 2'd0;
  localparam logic [1:0] RX_START = 2'd1;
  localparam logic [1:0] RX_DATA  = 2'd2;
  localparam logic [1:0] RX_STOP  = 2'd3;

  localparam logic [2:0] LD_LEN  = 3'd0;
  localparam logic [2:0] LD_DATA = 3'd1;
  localparam logic [2:0] LD_RUN  = 3'd3;
  localparam logic [2:0] LD_HALT = 3'd4;
`ifdef LOADER_CHECKSUM_EN
  localparam logic [2:0] LD_CSUM  = 3'd2;
  localparam logic [2:0] LD_FINAL = LD_CSUM;
`else
  localparam logic [2:0] LD_FINAL = LD_RUN;
`endif

  localparam int              CNT_W     = $clog2(CLK_PER_BIT);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLK_PER_BIT - 1);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLK_PER_BIT / 2 - 1);
  localparam logic [32:0]     MAX_WORDS = 33'(1) << ADDR_W;
  localparam logic [ADDR_W:0] LAST_WORD = (ADDR_W + 1)'(1);

  logic             rx_meta, rx_sync;
  logic [1:0]       rx_state;
  logic [CNT_W-1:0] rx_cnt;
  logic [2:0]       rx_bits;
  logic [7:0]       rx_shift, rx_byte;
  logic             byte_valid, frame_err;

  logic [2:0]        ld_state;
  logic [1:0]        byte_cnt;
  logic [23:0]       assembly;
  logic [31:0]       rx_word;
  logic [ADDR_W-1:0] wp;
  logic [ADDR_W:0]   words_left;
  logic              wr_pend;
  logic [31:0]       wr_data;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]        csum;
`endif
  logic              unused_adr_bits;

  always_ff @(posedge clk) begin
    if (!rstn) begin
      rx_meta    <= 1'b1;
      rx_sync    <= 1'b1;
      rx_state   <= RX_IDLE;
      rx_cnt     <= '0;
      rx_bits    <= '0;
      rx_shift   <= '0;
      rx_byte    <= '0;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      rx_meta    <= rxd;
      rx_sync    <= rx_meta;
      byte_valid <= 1'b0;
      frame_err  <= 1'b0;
      case (rx_state)
        RX_IDLE: begin
          if (!rx_sync) begin
            rx_state <= RX_START;
            rx_cnt   <= HALF_LAST;
          end
        end
        RX_START: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 1'b1;
          end else if (!rx_sync) begin
            rx_state <= RX_DATA;
            rx_cnt   <= BIT_LAST;
            rx_bits  <= '0;
          end else begin
            rx_state <= RX_IDLE;
          end
        end
        RX_DATA: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 1'b1;
          end else begin
            rx_shift <= {rx_sync, rx_shift[7:1]};
            rx_cnt   <= BIT_LAST;
            rx_bits  <= rx_bits + 3'd1;
            if (rx_bits == 3'd7) rx_state <= RX_STOP;
          end
        end
        default: begin
          if (rx_cnt != '0) begin
            rx_cnt <= rx_cnt - 1'b1;
          end else begin
            rx_state <= RX_IDLE;
            if (rx_sync) begin
              byte_valid <= 1'b1;
              rx_byte    <= rx_shift;
            end else begin
              frame_err <= 1'b1;
            end
          end
        end
      endcase
    end
  end

  assign rx_word = {rx_byte, assembly};

  always_ff @(posedge clk) begin
    if (!rstn) begin
      ld_state   <= LD_LEN;
      byte_cnt   <= '0;
      assembly   <= '0;
      wp         <= '0;
      words_left <= '0;
      wr_pend    <= 1'b0;
      wr_data    <= '0;
      load_err   <= 1'b0;
      core_rstn  <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
      csum       <= '0;
`endif
    end else begin
      wr_pend   <= 1'b0;
      core_rstn <= (ld_state == LD_RUN);
      if (frame_err) load_err <= 1'b1;

      // The write register is separate from the assembly register, so a byte
      // landing on a write cycle is still assembled normally.
      if (wr_pend) begin
        wp         <= wp + 1'b1;
        words_left <= words_left - 1'b1;
        if (words_left == LAST_WORD) ld_state <= LD_FINAL;
      end

      if (byte_valid && (ld_state == LD_LEN || ld_state == LD_DATA)) begin
        byte_cnt <= byte_cnt + 2'd1;
        assembly <= {rx_byte, assembly[23:8]};
`ifdef LOADER_CHECKSUM_EN
        csum     <= csum ^ rx_byte;
`endif
        if (byte_cnt == 2'd3) begin
          if (ld_state == LD_LEN) begin
            if (rx_word == '0) begin
              ld_state <= LD_FINAL;
            end else if ({1'b0, rx_word} > MAX_WORDS) begin
              load_err <= 1'b1;
              ld_state <= LD_HALT;
            end else begin
              ld_state   <= LD_DATA;
              wp         <= '0;
              words_left <= rx_word[ADDR_W:0];
            end
          end else begin
            wr_data <= rx_word;
            wr_pend <= 1'b1;
          end
        end
      end

`ifdef LOADER_CHECKSUM_EN
      if (byte_valid && ld_state == LD_CSUM) begin
        if (rx_byte == csum) begin
          ld_state <= LD_RUN;
        end else begin
          load_err <= 1'b1;
          ld_state <= LD_HALT;
        end
      end
`endif
    end
  end

  assign load_done     = (ld_state == LD_RUN);
  assign addra         = load_done ? core_adr[ADDR_W+1:2] : wp;
  assign dina          = load_done ? core_writedata : wr_data;
  assign wea           = load_done ? core_memwrite : wr_pend;
  assign core_readdata = douta;

  assign unused_adr_bits = ^{core_adr[31:ADDR_W+2], core_adr[1:0]};

endmodule

// File: tb/tb_uart_program_loader.sv
// Scoreboard bench for uart_program_loader: expected BRAM writes come from a byte-level
// image model; a monitor pops them on every wea. Honours LOADER_CHECKSUM_EN.
module tb_uart_program_loader;
  localparam int CPB = 8;
  localparam int AW  = 20;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          rxd = 1'b1;
  logic          core_rstn;
  logic [31:0]   core_adr = '0;
  logic [31:0]   core_writedata = '0;
  logic          core_memwrite = 1'b0;
  logic [31:0]   core_readdata;
  logic [AW-1:0] addra;
  logic          wea;
  logic [31:0]   dina;
  logic [31:0]   douta = '0;
  logic          load_done;
  logic          load_err;

  uart_program_loader #(.CLK_PER_BIT(CPB), .ADDR_W(AW)) dut (
    .clk(clk), .rstn(rstn), .rxd(rxd), .core_rstn(core_rstn),
    .core_adr(core_adr), .core_writedata(core_writedata), .core_memwrite(core_memwrite),
    .core_readdata(core_readdata), .addra(addra), .wea(wea), .dina(dina), .douta(douta),
    .load_done(load_done), .load_err(load_err)
  );

  always #5 clk = ~clk;

  typedef logic [8:0]  item_q_t[$];   // bit 8 set = send with a broken stop bit
  typedef logic [31:0] word_q_t[$];
  typedef struct packed {logic [AW-1:0] a; logic [31:0] d;} wr_t;

  wr_t sb[$];
  int  checks = 0;
  int  errors = 0;
  bit  done_q = 1'b0;
  bit  rstn_pending = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    wr_t e;
    if (rstn && wea) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_wea: actual addra=%0h dina=%h, required no write", addra, dina);
      end else begin
        e = sb.pop_front();
        if (addra !== e.a || dina !== e.d) begin
          errors++;
          $display("FAIL bram_write: actual addra=%0h dina=%h, required addra=%0h dina=%h",
                   addra, dina, e.a, e.d);
        end
      end
    end
  end

  // core reset must be released exactly one cycle after RUN is entered
  always @(negedge clk) begin
    if (rstn_pending) chk("core_rstn_release", core_rstn, 1);
    rstn_pending = 1'b0;
    if (rstn && load_done && !done_q) begin
      chk("core_rstn_at_run_entry", core_rstn, 0);
      rstn_pending = 1'b1;
    end
    done_q = load_done;
  end

  function automatic item_q_t make_image(input word_q_t words);
    item_q_t it;
    logic [31:0] n;
    logic [7:0] x;
    n = 32'(words.size());
    for (int i = 0; i < 4; i++) it.push_back({1'b0, n[8*i +: 8]});
    foreach (words[w])
      for (int i = 0; i < 4; i++) it.push_back({1'b0, words[w][8*i +: 8]});
    x = '0;
    foreach (it[i]) x ^= it[i][7:0];
`ifdef LOADER_CHECKSUM_EN
    it.push_back({1'b0, x});
`endif
    return it;
  endfunction

  // Reference: drop framed-bad bytes, parse length/words, push expected writes.
  task automatic model(input item_q_t items, output bit done, output bit err);
    logic [7:0] g[$];
    longint n;
    done = 1'b0;
    err  = 1'b0;
    foreach (items[i]) begin
      if (items[i][8]) err = 1'b1;
      else g.push_back(items[i][7:0]);
    end
    if (g.size() < 4) return;
    n = longint'({g[3], g[2], g[1], g[0]});
    if (n > (longint'(1) << AW)) begin
      err = 1'b1;
      return;
    end
    for (int w = 0; w < n; w++) begin
      if (g.size() < 8 + 4 * w) return;
      sb.push_back('{a: AW'(w), d: {g[4*w+7], g[4*w+6], g[4*w+5], g[4*w+4]}});
    end
`ifdef LOADER_CHECKSUM_EN
    begin
      int need;
      logic [7:0] x;
      need = 4 + 4 * int'(n);
      if (g.size() <= need) return;
      x = '0;
      for (int i = 0; i < need; i++) x ^= g[i];
      if (g[need] == x) done = 1'b1;
      else err = 1'b1;
    end
`else
    done = 1'b1;
`endif
  endtask

  task automatic send_byte(input logic [8:0] it);
    @(negedge clk);
    rxd = 1'b0;
    repeat (CPB) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      rxd = it[i];
      repeat (CPB) @(negedge clk);
    end
    rxd = ~it[8];
    repeat (CPB) @(negedge clk);
    rxd = 1'b1;
    repeat (2 * CPB) @(negedge clk);
  endtask

  task automatic send_items(input item_q_t items);
    foreach (items[i]) send_byte(items[i]);
  endtask

  task automatic run_image(input item_q_t items, input string name);
    bit exp_done, exp_err;
    model(items, exp_done, exp_err);
    send_items(items);
    repeat (4 * CPB) @(negedge clk);
    chk({name, "_load_done"}, load_done, exp_done);
    chk({name, "_load_err"}, load_err, exp_err);
    chk({name, "_core_rstn"}, core_rstn, exp_done);
    chk({name, "_writes_missing"}, sb.size(), 0);
  endtask

  task automatic do_reset();
    chk("writes_missing_before_reset", sb.size(), 0);
    sb.delete();
    @(negedge clk);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    chk("rst_core_rstn", core_rstn, 0);
    chk("rst_load_done", load_done, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_wea", wea, 0);
    chk("rst_addra", addra, 0);
    chk("rst_dina", dina, 0);
  endtask

  task automatic core_write(input logic [31:0] adr, input logic [31:0] data);
    @(posedge clk);
    #1;
    sb.push_back('{a: adr[AW+1:2], d: data});
    core_adr       = adr;
    core_writedata = data;
    core_memwrite  = 1'b1;
    douta          = $urandom;
    @(negedge clk);
    chk("core_readdata", core_readdata, douta);
    @(posedge clk);
    #1;
    core_memwrite = 1'b0;
  endtask

  initial begin
    item_q_t it;
    word_q_t w;
    word_q_t none;

    repeat (3) @(negedge clk);
    rstn = 1'b1;
    do_reset();

    w = '{32'h0000_0013, 32'h0000_006F};
    run_image(make_image(w), "two_word");

    do_reset();
    run_image(make_image(none), "zero_len");
    core_write(32'h0000_0008, 32'hDEAD_BEEF);
    core_write({$urandom, 2'b00}, $urandom);

    do_reset();
    w = '{32'hDDCC_BBAA};
    it = make_image(w);
    it.insert(4, 9'h155);
    run_image(it, "frame_err");

    do_reset();
    core_memwrite = 1'b1;
    core_adr = $urandom;
    @(negedge clk);
    rxd = 1'b0;
    repeat (2) @(negedge clk);
    rxd = 1'b1;
    repeat (4 * CPB) @(negedge clk);
    chk("glitch_load_err", load_err, 0);
    chk("glitch_load_done", load_done, 0);
    core_memwrite = 1'b0;
    w = '{$urandom};
    run_image(make_image(w), "after_glitch");

    do_reset();
    it = '{9'h001, 9'h000, 9'h000, 9'h000, 9'h0AA, 9'h0BB};
    send_items(it);
    do_reset();
    w = '{$urandom};
    run_image(make_image(w), "after_midload_reset");

    do_reset();
    core_memwrite = 1'b1;
    core_adr = $urandom;
    it = '{9'h001, 9'h000, 9'h010, 9'h000, 9'h0AA, 9'h0BB, 9'h0CC, 9'h0DD};
    run_image(it, "too_long");
    core_memwrite = 1'b0;

    for (int k = 0; k < 5; k++) begin
      do_reset();
      w.delete();
      for (int i = 0; i < int'($urandom_range(1, 4)); i++) w.push_back($urandom);
      it = make_image(w);
      if (k % 2 == 1) it.insert($urandom_range(4, it.size() - 1), {1'b1, 8'($urandom)});
      run_image(it, $sformatf("random%0d", k));
    end

`ifdef LOADER_CHECKSUM_EN
    do_reset();
    w = '{32'h4433_2211};
    run_image(make_image(w), "csum_good");
    do_reset();
    it = make_image(w);
    it[it.size() - 1] = 9'h000;
    run_image(it, "csum_bad");
`endif

    do_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
